// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the SPI link endpoints.
//   SPI_WORD_WIDTH : default word length of the link.
//   rx_state_t     : receive FSM states.
//   cpol(mode)     : clock idle level for SPI mode 0..3.
//   cpha(mode)     : 0 = sample on leading edge, 1 = sample on trailing edge.
package spi_pkg;

  localparam int SPI_WORD_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  function automatic logic cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Word handshake between the SPI receiver and the core.
//   rx_word     : last accepted word (receiver -> core)
//   rx_valid    : rx_word holds an unconsumed word (receiver -> core)
//   rx_ready    : core accepts the word when high with rx_valid (core -> receiver)
//   rx_overrun  : sticky, a word was dropped because rx_valid was held (receiver -> core)
//   clr_overrun : one-cycle clear of rx_overrun (core -> receiver)
//   frame_err   : one-cycle pulse, chip select rose mid-word (receiver -> core)
// Modport slave is the receiver side, master is the consuming core.
interface spi_slave_rx_if
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = SPI_WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] rx_word;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_overrun;
  logic                  clr_overrun;
  logic                  frame_err;

  modport slave (
    output rx_word,
    output rx_valid,
    input  rx_ready,
    output rx_overrun,
    input  clr_overrun,
    output frame_err
  );

  modport master (
    input  rx_word,
    input  rx_valid,
    output rx_ready,
    input  rx_overrun,
    output clr_overrun,
    input  frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge detector for an asynchronous clock-like input.
//   i_Clk, i_Rst_L : system clock, asynchronous active-low reset
//   async_in       : asynchronous input (SCLK)
//   lead_edge      : one-cycle pulse when the synced level leaves IDLE_LEVEL
//   trail_edge     : one-cycle pulse when the synced level returns to IDLE_LEVEL
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic async_in,
  output logic lead_edge,
  output logic trail_edge
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_d_reg;
  logic                   level;

  assign level = sync_reg[SYNC_STAGES-1];

  // Reset to the idle level so leaving reset never fakes an edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_reg    <= {SYNC_STAGES{IDLE_LEVEL}};
      level_d_reg <= IDLE_LEVEL;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], async_in};
      level_d_reg <= level;
    end
  end

  assign lead_edge  = (level_d_reg == IDLE_LEVEL) && (level != IDLE_LEVEL);
  assign trail_edge = (level_d_reg != IDLE_LEVEL) && (level == IDLE_LEVEL);

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave: synchronises SCLK/MOSI/CS_n into i_Clk, shifts in
// MSB-first words and presents them on a valid/ready handshake.
//   i_Clk       : system clock, >= 4x SCLK
//   i_Rst_L     : asynchronous active-low reset
//   i_SPI_Clk   : SCLK from the master (asynchronous)
//   i_SPI_MOSI  : serial data from the master (asynchronous)
//   i_SPI_CS_n  : active-low chip select (asynchronous)
//   rx_bus      : word handshake, overrun flag/clear and frame error pulse
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 0,
  parameter int WORD_WIDTH  = SPI_WORD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_SPI_Clk,
  input  logic          i_SPI_MOSI,
  input  logic          i_SPI_CS_n,
  spi_slave_rx_if.slave rx_bus
);

  localparam logic CPOL  = cpol(SPI_MODE);
  localparam logic CPHA  = cpha(SPI_MODE);
  localparam int   CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] cs_n_sync_reg;
  logic                   mosi;
  logic                   cs_n;

  rx_state_t              state_reg;
  logic [WORD_WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic                   done_reg;
  logic                   frame_err_reg;
  logic [WORD_WIDTH-1:0]  word_reg;
  logic                   valid_reg;
  logic                   overrun_reg;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (CPOL)
  ) u_sclk_sync (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .async_in   (i_SPI_Clk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  // MOSI and CS_n get the same depth as SCLK so all three stay aligned.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mosi_sync_reg <= '0;
      cs_n_sync_reg <= '1;
    end else begin
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_SPI_MOSI};
      cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], i_SPI_CS_n};
    end
  end

  assign mosi        = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_n        = cs_n_sync_reg[SYNC_STAGES-1];
  assign sample_edge = CPHA ? trail_edge : lead_edge;

  // Framing FSM. done_reg marks the cycle after the final sample edge,
  // when shift_reg holds the complete word.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          bit_cnt_reg <= '0;
          if (!cs_n) state_reg <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_n) begin
            // Deselect ends the frame; a partial word is thrown away.
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            frame_err_reg <= (bit_cnt_reg != '0);
          end else if (sample_edge) begin
            shift_reg <= {shift_reg[WORD_WIDTH-2:0], mosi};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_reg <= '0;
              done_reg    <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Output word register and handshake. A completion that coincides with
  // the consumer taking the pending word replaces it without a gap.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (done_reg) begin
        if (!valid_reg || rx_bus.rx_ready) begin
          word_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end
      end else if (valid_reg && rx_bus.rx_ready) begin
        valid_reg <= 1'b0;
      end

      // A new overrun beats a simultaneous clear.
      if (done_reg && valid_reg && !rx_bus.rx_ready) begin
        overrun_reg <= 1'b1;
      end else if (rx_bus.clr_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_word    = word_reg;
  assign rx_bus.rx_valid   = valid_reg;
  assign rx_bus.rx_overrun = overrun_reg;
  assign rx_bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench: one receiver instance per SPI mode (instance m runs mode m),
// sharing SCLK/MOSI and selected individually by their own CS_n.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int HALF = 4;  // SCLK half-period in i_Clk cycles

  logic clk;
  logic rst_l;
  logic sclk;
  logic mosi;
  logic [3:0] cs_n_v;
  logic [3:0] ready_v;
  logic [3:0] clr_v;
  logic [3:0] valid_v;
  logic [3:0] ovr_v;
  logic [3:0] ferr_v;
  logic [31:0] word_v [4];

  int checks = 0;
  int errors = 0;
  int acc_cnt [4];
  int ferr_cnt [4];
  logic [31:0] acc_words [4][16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_rx_if #(.WORD_WIDTH(32)) if0 ();
  spi_slave_rx_if #(.WORD_WIDTH(32)) if1 ();
  spi_slave_rx_if #(.WORD_WIDTH(32)) if2 ();
  spi_slave_rx_if #(.WORD_WIDTH(32)) if3 ();

  spi_slave_rx #(.SPI_MODE(0), .WORD_WIDTH(32), .SYNC_STAGES(2)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n_v[0]), .rx_bus(if0));
  spi_slave_rx #(.SPI_MODE(1), .WORD_WIDTH(32), .SYNC_STAGES(2)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n_v[1]), .rx_bus(if1));
  spi_slave_rx #(.SPI_MODE(2), .WORD_WIDTH(32), .SYNC_STAGES(2)) u_dut2 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n_v[2]), .rx_bus(if2));
  spi_slave_rx #(.SPI_MODE(3), .WORD_WIDTH(32), .SYNC_STAGES(2)) u_dut3 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs_n_v[3]), .rx_bus(if3));

  assign if0.rx_ready = ready_v[0];  assign if0.clr_overrun = clr_v[0];
  assign if1.rx_ready = ready_v[1];  assign if1.clr_overrun = clr_v[1];
  assign if2.rx_ready = ready_v[2];  assign if2.clr_overrun = clr_v[2];
  assign if3.rx_ready = ready_v[3];  assign if3.clr_overrun = clr_v[3];

  assign valid_v = {if3.rx_valid, if2.rx_valid, if1.rx_valid, if0.rx_valid};
  assign ovr_v   = {if3.rx_overrun, if2.rx_overrun, if1.rx_overrun, if0.rx_overrun};
  assign ferr_v  = {if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
  assign word_v[0] = if0.rx_word;
  assign word_v[1] = if1.rx_word;
  assign word_v[2] = if2.rx_word;
  assign word_v[3] = if3.rx_word;

  // Record every handshake acceptance and every frame error cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (valid_v[m] && ready_v[m]) begin
        if (acc_cnt[m] < 16) acc_words[m][acc_cnt[m]] = word_v[m];
        acc_cnt[m]++;
      end
      if (ferr_v[m]) ferr_cnt[m]++;
    end
  end

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_begin(input int m);
    @(negedge clk);
    sclk = cpol(m);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs_n_v[m] = 1'b0;
    half();
    half();
  endtask

  task automatic cs_end(input int m);
    half();
    cs_n_v[m] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Send the top n bits of w, MSB first, in mode m.
  task automatic spi_bits(input int m, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (!cpha(m)) begin
        mosi = w[31-i];
        half();
        sclk = ~sclk;
        half();
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = w[31-i];
        half();
        sclk = ~sclk;
        half();
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++; if (valid_v[m] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", m, valid_v[m]); end
      checks++; if (word_v[m] !== 32'h0) begin errors++; $display("FAIL reset_word[%0d]: got %h expected 00000000", m, word_v[m]); end
      checks++; if (ovr_v[m] !== 1'b0) begin errors++; $display("FAIL reset_overrun[%0d]: got %b expected 0", m, ovr_v[m]); end
      checks++; if (ferr_v[m] !== 1'b0) begin errors++; $display("FAIL reset_frame_err[%0d]: got %b expected 0", m, ferr_v[m]); end
    end
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mode0_single();
    int a0;
    int f0;
    a0 = acc_cnt[0];
    f0 = ferr_cnt[0];
    ready_v[0] = 1'b1;
    cs_begin(0);
    spi_bits(0, 32'hA5C3_0F96, 32);
    cs_end(0);
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL m0_accept_count: got %0d expected 1", acc_cnt[0] - a0); end
    checks++; if (acc_words[0][a0] !== 32'hA5C3_0F96) begin errors++; $display("FAIL m0_word: got %h expected a5c30f96", acc_words[0][a0]); end
    checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL m0_valid_after: got %b expected 0", valid_v[0]); end
    checks++; if (ovr_v[0] !== 1'b0) begin errors++; $display("FAIL m0_overrun: got %b expected 0", ovr_v[0]); end
    checks++; if (ferr_cnt[0] - f0 !== 0) begin errors++; $display("FAIL m0_frame_err: got %0d expected 0", ferr_cnt[0] - f0); end
    $display("test_mode0_single done: word %h", word_v[0]);
  endtask

  task automatic test_back_to_back();
    int a0;
    int f0;
    a0 = acc_cnt[3];
    f0 = ferr_cnt[3];
    ready_v[3] = 1'b1;
    cs_begin(3);
    spi_bits(3, 32'hDEAD_BEEF, 32);
    spi_bits(3, 32'h0123_4567, 32);
    cs_end(3);
    checks++; if (acc_cnt[3] - a0 !== 2) begin errors++; $display("FAIL m3_accept_count: got %0d expected 2", acc_cnt[3] - a0); end
    checks++; if (acc_words[3][a0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL m3_word0: got %h expected deadbeef", acc_words[3][a0]); end
    checks++; if (acc_words[3][a0+1] !== 32'h0123_4567) begin errors++; $display("FAIL m3_word1: got %h expected 01234567", acc_words[3][a0+1]); end
    checks++; if (ovr_v[3] !== 1'b0) begin errors++; $display("FAIL m3_overrun: got %b expected 0", ovr_v[3]); end
    checks++; if (ferr_cnt[3] - f0 !== 0) begin errors++; $display("FAIL m3_frame_err: got %0d expected 0", ferr_cnt[3] - f0); end
    $display("test_back_to_back done: words %h %h", acc_words[3][a0], acc_words[3][a0+1]);
  endtask

  task automatic test_overrun();
    int a0;
    a0 = acc_cnt[1];
    ready_v[1] = 1'b0;
    cs_begin(1);
    spi_bits(1, 32'h1111_1111, 32);
    spi_bits(1, 32'h2222_2222, 32);
    cs_end(1);
    checks++; if (valid_v[1] !== 1'b1) begin errors++; $display("FAIL m1_valid_held: got %b expected 1", valid_v[1]); end
    checks++; if (word_v[1] !== 32'h1111_1111) begin errors++; $display("FAIL m1_word_kept: got %h expected 11111111", word_v[1]); end
    checks++; if (ovr_v[1] !== 1'b1) begin errors++; $display("FAIL m1_overrun_set: got %b expected 1", ovr_v[1]); end
    checks++; if (acc_cnt[1] - a0 !== 0) begin errors++; $display("FAIL m1_no_accept: got %0d expected 0", acc_cnt[1] - a0); end
    @(posedge clk); #1 clr_v[1] = 1'b1;
    @(posedge clk); #1 clr_v[1] = 1'b0;
    @(negedge clk);
    checks++; if (ovr_v[1] !== 1'b0) begin errors++; $display("FAIL m1_overrun_clr: got %b expected 0", ovr_v[1]); end
    checks++; if (valid_v[1] !== 1'b1) begin errors++; $display("FAIL m1_valid_after_clr: got %b expected 1", valid_v[1]); end
    @(posedge clk); #1 ready_v[1] = 1'b1;
    @(posedge clk); #1 ready_v[1] = 1'b0;
    @(negedge clk);
    checks++; if (valid_v[1] !== 1'b0) begin errors++; $display("FAIL m1_valid_drained: got %b expected 0", valid_v[1]); end
    checks++; if (acc_words[1][a0] !== 32'h1111_1111) begin errors++; $display("FAIL m1_drained_word: got %h expected 11111111", acc_words[1][a0]); end
    $display("test_overrun done: word %h overrun %b", word_v[1], ovr_v[1]);
  endtask

  task automatic test_frame_err();
    int a0;
    int f0;
    a0 = acc_cnt[2];
    f0 = ferr_cnt[2];
    ready_v[2] = 1'b1;
    cs_begin(2);
    spi_bits(2, 32'hFFC0_0000, 10);
    cs_end(2);
    checks++; if (ferr_cnt[2] - f0 !== 1) begin errors++; $display("FAIL m2_frame_err_cycles: got %0d expected 1", ferr_cnt[2] - f0); end
    checks++; if (acc_cnt[2] - a0 !== 0) begin errors++; $display("FAIL m2_abort_no_valid: got %0d expected 0", acc_cnt[2] - a0); end
    cs_begin(2);
    spi_bits(2, 32'h1234_5678, 32);
    cs_end(2);
    checks++; if (acc_cnt[2] - a0 !== 1) begin errors++; $display("FAIL m2_accept_count: got %0d expected 1", acc_cnt[2] - a0); end
    checks++; if (acc_words[2][a0] !== 32'h1234_5678) begin errors++; $display("FAIL m2_word: got %h expected 12345678", acc_words[2][a0]); end
    checks++; if (ferr_cnt[2] - f0 !== 1) begin errors++; $display("FAIL m2_no_extra_frame_err: got %0d expected 1", ferr_cnt[2] - f0); end
    $display("test_frame_err done: word %h", acc_words[2][a0]);
  endtask

  task automatic test_reset_mid_word();
    int a0;
    int f0;
    ready_v[0] = 1'b0;
    cs_begin(0);
    spi_bits(0, 32'hCAFE_F00D, 32);
    cs_end(0);
    checks++; if (valid_v[0] !== 1'b1) begin errors++; $display("FAIL rst_pending_valid: got %b expected 1", valid_v[0]); end
    checks++; if (word_v[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_pending_word: got %h expected cafef00d", word_v[0]); end
    cs_begin(0);
    spi_bits(0, 32'hFFFF_0000, 17);
    rst_l = 1'b0;
    #1;
    checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", valid_v[0]); end
    checks++; if (word_v[0] !== 32'h0) begin errors++; $display("FAIL rst_async_word: got %h expected 00000000", word_v[0]); end
    checks++; if (ovr_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_overrun: got %b expected 0", ovr_v[0]); end
    checks++; if (ferr_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_frame_err: got %b expected 0", ferr_v[0]); end
    cs_n_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    a0 = acc_cnt[0];
    f0 = ferr_cnt[0];
    ready_v[0] = 1'b1;
    cs_begin(0);
    spi_bits(0, 32'h0F0F_0F0F, 32);
    cs_end(0);
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL rst_next_accept: got %0d expected 1", acc_cnt[0] - a0); end
    checks++; if (acc_words[0][a0] !== 32'h0F0F_0F0F) begin errors++; $display("FAIL rst_next_word: got %h expected 0f0f0f0f", acc_words[0][a0]); end
    checks++; if (ferr_cnt[0] - f0 !== 0) begin errors++; $display("FAIL rst_next_frame_err: got %0d expected 0", ferr_cnt[0] - f0); end
    $display("test_reset_mid_word done: word %h", acc_words[0][a0]);
  endtask

  // Ready is raised only in the completion cycle of the second word:
  // final SCLK pin edge + SYNC_STAGES + 1 posedges.
  task automatic test_coincident_ready();
    int a0;
    ready_v[0] = 1'b0;
    cs_begin(0);
    spi_bits(0, 32'h5A5A_1234, 32);
    cs_end(0);
    a0 = acc_cnt[0];
    checks++; if (valid_v[0] !== 1'b1) begin errors++; $display("FAIL co_pending_valid: got %b expected 1", valid_v[0]); end
    cs_begin(0);
    spi_bits(0, 32'h8765_4321, 31);
    mosi = 1'b1;
    half();
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready_v[0] = 1'b1;
    @(posedge clk);
    #1 ready_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (valid_v[0] !== 1'b1) begin errors++; $display("FAIL co_valid_stays: got %b expected 1", valid_v[0]); end
    checks++; if (word_v[0] !== 32'h8765_4321) begin errors++; $display("FAIL co_new_word: got %h expected 87654321", word_v[0]); end
    checks++; if (ovr_v[0] !== 1'b0) begin errors++; $display("FAIL co_no_overrun: got %b expected 0", ovr_v[0]); end
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL co_old_accept: got %0d expected 1", acc_cnt[0] - a0); end
    checks++; if (acc_words[0][a0] !== 32'h5A5A_1234) begin errors++; $display("FAIL co_old_word: got %h expected 5a5a1234", acc_words[0][a0]); end
    half();
    sclk = 1'b0;
    cs_end(0);
    $display("test_coincident_ready done: word %h", word_v[0]);
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      acc_cnt[m]  = 0;
      ferr_cnt[m] = 0;
    end
    rst_l   = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cs_n_v  = 4'hF;
    ready_v = 4'h0;
    clr_v   = 4'h0;
    test_reset();
    test_mode0_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid_word();
    test_coincident_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
